// File: rtl/nt_pkg.sv
// Shared nucleotide definitions: symbol width, 3-bit base codes, stream direction and
// the unpacker state encoding.
package nt_pkg;

    localparam int unsigned SYM_W = 3;

    localparam logic [SYM_W-1:0] NT_A   = 3'd0;
    localparam logic [SYM_W-1:0] NT_C   = 3'd1;
    localparam logic [SYM_W-1:0] NT_G   = 3'd2;
    localparam logic [SYM_W-1:0] NT_T   = 3'd3;
    localparam logic [SYM_W-1:0] NT_N   = 3'd4;
    localparam logic [SYM_W-1:0] NT_PAD = 3'd7;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/symbol_unpacker_if.sv
// Packed-word input stream and per-symbol output stream of the symbol unpacker.
interface symbol_unpacker_if #(
    parameter int unsigned SYM_W = nt_pkg::SYM_W,
    parameter int unsigned N_SYM = 8,
    parameter int unsigned CNT_W = $clog2(N_SYM + 1)
);
    logic [N_SYM*SYM_W-1:0] in_word;
    logic [CNT_W-1:0]       in_count;
    logic                   in_dir;
    logic                   in_valid;
    logic                   in_ready;
    logic [SYM_W-1:0]       sym_out;
    logic                   sym_dir;
    logic                   sym_valid;
    logic                   sym_ready;
    logic                   sym_last;

    // Environment side: produces words, consumes symbols.
    modport master (
        output in_word, in_count, in_dir, in_valid, sym_ready,
        input  in_ready, sym_out, sym_dir, sym_valid, sym_last
    );

    // Unpacker side.
    modport slave (
        input  in_word, in_count, in_dir, in_valid, sym_ready,
        output in_ready, sym_out, sym_dir, sym_valid, sym_last
    );
endinterface

// File: rtl/symbol_unpacker.sv
// Splits packed nucleotide words into a one-symbol-per-cycle stream feeding the
// sliding-window shift register, forward or reverse per word.
module symbol_unpacker
    import nt_pkg::*;
#(
    parameter int unsigned N_SYM = 8,
    parameter int unsigned CNT_W = $clog2(N_SYM + 1)
) (
    input  logic              clk,
    input  logic              reset,
    symbol_unpacker_if.slave  bus,
    output logic              busy
);
    localparam int unsigned IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

    state_t                       state;
    logic [N_SYM-1:0][SYM_W-1:0]  word_q;
    logic [N_SYM-1:0][SYM_W-1:0]  in_syms;
    logic [CNT_W-1:0]             idx;
    logic [CNT_W-1:0]             rem;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             first;
    logic [CNT_W-1:0]             nidx;
    logic [SYM_W-1:0]             sym_out_q;
    logic                         sym_dir_q;
    logic                         sym_valid_q;
    logic                         sym_last_q;
    logic                         in_ready;
    logic                         accept;
    logic                         take;

    always_comb begin
        in_syms = bus.in_word;
        cnt     = (bus.in_count > CNT_W'(N_SYM)) ? CNT_W'(N_SYM) : bus.in_count;
        first   = (bus.in_dir == DIR_REV) ? cnt - CNT_W'(1) : '0;
        nidx    = (sym_dir_q == DIR_REV) ? idx - CNT_W'(1) : idx + CNT_W'(1);
    end

    // in_ready in STREAM depends combinationally on sym_ready so the next word
    // can be taken on the same cycle the last symbol leaves.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (state == IDLE) ? 1'b1 : (bus.sym_ready & sym_last_q);
        end
    end

    // Zero-count words still complete the input handshake but load nothing.
    assign accept = bus.in_valid & in_ready & (cnt != '0);
    assign take   = sym_valid_q & bus.sym_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            word_q      <= '0;
            idx         <= '0;
            rem         <= '0;
            sym_out_q   <= '0;
            sym_dir_q   <= DIR_FWD;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
        end else if (accept && (state == IDLE || (take && sym_last_q))) begin
            state       <= STREAM;
            word_q      <= in_syms;
            idx         <= first;
            rem         <= cnt;
            sym_out_q   <= in_syms[first[IDX_W-1:0]];
            sym_dir_q   <= bus.in_dir;
            sym_valid_q <= 1'b1;
            sym_last_q  <= (cnt == CNT_W'(1));
        end else if (state == STREAM && take) begin
            if (sym_last_q) begin
                state       <= IDLE;
                sym_valid_q <= 1'b0;
                sym_last_q  <= 1'b0;
            end else begin
                idx        <= nidx;
                rem        <= rem - CNT_W'(1);
                sym_out_q  <= word_q[nidx[IDX_W-1:0]];
                sym_last_q <= (rem == CNT_W'(2));
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_dir   = sym_dir_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_last  = sym_last_q;
    assign busy          = (state == STREAM);

endmodule

// File: tb/tb_symbol_unpacker.sv
// Directed bench for symbol_unpacker: forward/reverse, backpressure, back-to-back words,
// count edge cases and reset mid-word.
module tb_symbol_unpacker;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    symbol_unpacker_if #(.N_SYM(8)) bus ();

    symbol_unpacker #(.N_SYM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_sym(input string tag, input int sym, input int dir, input int last);
        chk({tag, ".valid"}, 32'(bus.sym_valid), 32'd1);
        chk({tag, ".sym"},   32'(bus.sym_out),   32'(sym));
        chk({tag, ".dir"},   32'(bus.sym_dir),   32'(dir));
        chk({tag, ".last"},  32'(bus.sym_last),  32'(last));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] w, input logic [3:0] c, input logic d);
        bus.in_word  = w;
        bus.in_count = c;
        bus.in_dir   = d;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_word   = '0;
        bus.in_count  = '0;
        bus.in_dir    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sym_ready = 1'b0;
        tick();
        tick();
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.valid",    32'(bus.sym_valid), 32'd0);
        chk("rst.sym",      32'(bus.sym_out), 32'd0);
        chk("rst.dir",      32'(bus.sym_dir), 32'd0);
        chk("rst.last",     32'(bus.sym_last), 32'd0);
        chk("rst.busy",     32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle.in_ready", 32'(bus.in_ready), 32'd1);

        // 1: forward, full word
        bus.sym_ready = 1'b1;
        send(24'o76543210, 4'd8, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_sym($sformatf("fwd%0d", i), i, 0, int'(i == 7));
            tick();
        end
        chk("fwd.end_valid", 32'(bus.sym_valid), 32'd0);
        chk("fwd.end_busy",  32'(busy), 32'd0);

        // 2: reverse, partial word
        send(24'o76543210, 4'd5, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            expect_sym($sformatf("rev%0d", i), i, 1, int'(i == 0));
            tick();
        end
        chk("rev.end_valid", 32'(bus.sym_valid), 32'd0);

        // 3: backpressure after symbol 2
        send(24'o76543210, 4'd8, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_sym($sformatf("bp%0d", i), i, 0, int'(i == 7));
            if (i == 2) begin
                bus.sym_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    expect_sym($sformatf("bp_hold%0d", k), 2, 0, 0);
                end
                bus.sym_ready = 1'b1;
            end
            tick();
        end
        chk("bp.end_valid", 32'(bus.sym_valid), 32'd0);

        // 4: back-to-back words A then B
        send(24'o76543210, 4'd2, 1'b0);
        tick();
        send(24'o01234567, 4'd3, 1'b1);
        #1;
        expect_sym("b2b.a0", 0, 0, 0);
        chk("b2b.a0_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        expect_sym("b2b.a1", 1, 0, 1);
        chk("b2b.a1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        expect_sym("b2b.b0", 5, 1, 0);
        tick();
        expect_sym("b2b.b1", 6, 1, 0);
        tick();
        expect_sym("b2b.b2", 7, 1, 1);
        tick();
        chk("b2b.end_valid", 32'(bus.sym_valid), 32'd0);

        // 5: count edge cases
        send(24'o76543210, 4'd0, 1'b0);
        #1;
        chk("cnt0.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("cnt0.valid", 32'(bus.sym_valid), 32'd0);
        chk("cnt0.busy",  32'(busy), 32'd0);
        tick();
        chk("cnt0.valid2", 32'(bus.sym_valid), 32'd0);
        send(24'o76543210, 4'd9, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_sym($sformatf("cnt9_%0d", i), i, 0, int'(i == 7));
            tick();
        end
        chk("cnt9.end_valid", 32'(bus.sym_valid), 32'd0);

        // 6: reset mid-word
        send(24'o76543210, 4'd8, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_sym($sformatf("rstw%0d", i), i, 0, 0);
            if (i < 3) tick();
        end
        reset = 1'b1;
        tick();
        chk("rstw.valid",    32'(bus.sym_valid), 32'd0);
        chk("rstw.busy",     32'(busy), 32'd0);
        chk("rstw.in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rstw.in_ready_low", 32'(bus.in_ready), 32'd1);
        send(24'o01234567, 4'd8, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        expect_sym("rstw.new0", 7, 0, 0);
        tick();
        expect_sym("rstw.new1", 6, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
